// File: rtl/imem_loadable.sv
// Loadable instruction memory: a program is streamed in over a valid/ready port, then fetched
// with 1-cycle latency. Addresses at or beyond the loaded length read back FILL_OP.
module imem_loadable #(
    parameter int unsigned    AW      = 8,
    parameter int unsigned    DW      = 16,
    parameter int unsigned    DEPTH   = 256,
    parameter logic [DW-1:0]  FILL_OP = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    input  logic          fetch_en,
    output logic [DW-1:0] op,
    output logic          op_valid,
    output logic          run,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic [AW:0]   prog_len,
    output logic          ld_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          hit;
    logic [IW-1:0] waddr;
    logic [IW-1:0] raddr;

    // prog_len doubles as the write pointer: both advance together on every accepted word
    assign waddr = prog_len[IW-1:0];
    assign raddr = pc[IW-1:0];
    assign wr_en = (state == LOAD) && ld_valid && !ld_start;
    assign hit   = ({1'b0, pc} < prog_len);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            op       <= FILL_OP;
            op_valid <= 1'b0;
            run      <= 1'b0;
            ld_ready <= 1'b0;
            prog_len <= '0;
            ld_err   <= 1'b0;
        end else begin
            // Read uses the pre-edge prog_len and array contents, so a same-cycle write is not forwarded
            if (fetch_en) begin
                op       <= hit ? mem[raddr] : FILL_OP;
                op_valid <= 1'b1;
            end else begin
                op_valid <= 1'b0;
            end

            case (state)
                EMPTY, RUN: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        run      <= 1'b0;
                        ld_ready <= 1'b1;
                        prog_len <= '0;
                        ld_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        prog_len <= '0;
                        ld_err   <= 1'b0;
                    end else if (ld_valid) begin
                        prog_len <= prog_len + 1'b1;
                        if (ld_last || prog_len == LAST_ADDR) begin
                            state    <= RUN;
                            run      <= 1'b1;
                            ld_ready <= 1'b0;
                            ld_err   <= !ld_last;
                        end
                    end
                end
                default: begin
                    state    <= EMPTY;
                    run      <= 1'b0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
